// File: rtl/rr_enc_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin encoded arbiter.
interface rr_enc_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid
    );
endinterface

// File: rtl/rr_enc_arbiter.sv
// Round-robin arbiter for 4 requesters: registered one-hot grant plus its 2-bit index,
// hold-limited ownership and a mandatory idle bubble between consecutive owners.
module rr_enc_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 4
) (
    input logic             clk,
    input logic             rst,
    rr_enc_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       idx_q, idx_d;

    logic             found;
    logic [1:0]       sel;
    logic [1:0]       cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        found   = 1'b0;
        sel     = ptr_q;
        cand    = ptr_q;

        // First set request at or after the pointer, wrapping modulo 4.
        for (int unsigned k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = 4'b0001 << sel;
                    idx_d   = sel;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!bus.req[idx_q] || (cnt_q == CNT_W'(HOLD_MAX - 1))) begin
                    grant_d = '0;
                    idx_d   = '0;
                    ptr_d   = idx_q + 2'd1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = |grant_q;

endmodule
